// File: rtl/seqdet_pkg.sv
// Shared types and defaults for the seqdet_sched scheduler and its seq_det detector.
package seqdet_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    // Controller phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_e;

    // Detector history: S1 "1", S2 "11", S3 "111", S4 "10", S5 "100"
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } det_state_e;

endpackage

// File: rtl/seq_det.sv
// Six-state Mealy detector: z=1 when w completes "111" (overlapping) or "1001".
// Holds state and drives z=0 while en is low; clr returns it to S0.
module seq_det
    import seqdet_pkg::*;
(
    input  logic Clock,
    input  logic Resetn,
    input  logic clr,
    input  logic en,
    input  logic w,
    output logic z
);

    det_state_e state_q, state_d;

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Mealy output
    always_comb begin
        state_d = state_q;
        z       = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            unique case (state_q)
                S0: state_d = w ? S1 : S0;
                S1: state_d = w ? S2 : S4;
                S2: begin
                    state_d = w ? S3 : S4;
                    z       = w;
                end
                S3: begin
                    state_d = w ? S3 : S4;
                    z       = w;
                end
                S4: state_d = w ? S1 : S5;
                S5: begin
                    state_d = w ? S1 : S0;
                    z       = w;
                end
                default: state_d = S0;
            endcase
        end
    end

endmodule

// File: rtl/seqdet_sched.sv
// Two-requester round-robin scheduler feeding words MSB-first into seq_det and
// reporting the hit count per word. Defining SEQDET_SCHED_STATS_EN adds the
// total_cnt accumulator port.
module seqdet_sched
    import seqdet_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             det_w,
    output logic             det_z,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
`ifdef SEQDET_SCHED_STATS_EN
    ,
    output logic [15:0]      total_cnt
`endif
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ctrl_state_e      state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             ptr_q, ptr_d;
    logic             id_q, id_d;
    logic             did_q, did_d;
    logic             det_clr, det_en, sel, prio, can_grant;

    // State and datapath registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            gnt_q   <= 2'b00;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            did_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            did_q   <= did_d;
        end
    end

    // Arbitration, sequencing and counting
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        did_d   = did_q;
        gnt_d   = 2'b00;
        det_clr = 1'b0;
        det_en  = 1'b0;
        det_w   = 1'b0;

        // gnt is registered, so the choice for the next cycle is made in the
        // cycle before it. The report cycle already favours the other requester
        // so back-to-back words keep a WIDTH+2 cadence.
        can_grant = ((state_q == IDLE) && (gnt_q == 2'b00)) || (state_q == REPORT);
        prio      = (state_q == REPORT) ? ~id_q : ptr_q;
        sel       = (req == 2'b11) ? prio : req[1];
        if (can_grant && (req != 2'b00)) begin
            gnt_d = sel ? 2'b10 : 2'b01;
            id_d  = sel;
        end

        unique case (state_q)
            IDLE: begin
                // gnt_q high marks the grant cycle: sample the word now
                if (gnt_q != 2'b00) begin
                    sr_d    = id_q ? data1 : data0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    det_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_w  = sr_q[WIDTH-1];
                det_en = 1'b1;
                if (det_z && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                sr_d  = sr_q << 1;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(WIDTH - 1)) begin
                    mcnt_d  = cnt_d;
                    did_d   = id_q;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                ptr_d   = ~id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seq_det u_seq_det (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (det_clr),
        .en     (det_en),
        .w      (det_w),
        .z      (det_z)
    );

    assign gnt       = gnt_q;
    assign busy      = (state_q == SHIFT) || (state_q == REPORT);
    assign done      = (state_q == REPORT);
    assign done_id   = did_q;
    assign match_cnt = mcnt_q;

`ifdef SEQDET_SCHED_STATS_EN
    logic [15:0] total_q;

    // Running sum of reported counts, wrapping at 2^16
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            total_q <= '0;
        end else if (state_q == REPORT) begin
            total_q <= total_q + 16'(mcnt_q);
        end
    end

    assign total_cnt = total_q;
`endif

endmodule

// File: tb/tb_seqdet_sched.sv
// Directed bench for seqdet_sched: table of single-word transactions plus
// hand-written reset-abort and round-robin sequences.
module tb_seqdet_sched;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          Clock  = 1'b0;
    logic          Resetn = 1'b0;
    logic [1:0]    req    = 2'b00;
    logic [W-1:0]  data0  = '0;
    logic [W-1:0]  data1  = '0;
    logic [1:0]    gnt;
    logic          busy, det_w, det_z, done, done_id;
    logic [CW-1:0] match_cnt;
`ifdef SEQDET_SCHED_STATS_EN
    logic [15:0]   total_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_total = '0;

    typedef struct {
        logic [1:0]    req;
        logic [W-1:0]  d0;
        logic [W-1:0]  d1;
        logic [1:0]    gnt;
        logic          id;
        logic [CW-1:0] cnt;
        logic [W-1:0]  zmask;  // bit W-i set when det_z is expected on serial bit i
    } vec_t;

    vec_t tbl[6];

    seqdet_sched #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .gnt       (gnt),
        .busy      (busy),
        .det_w     (det_w),
        .det_z     (det_z),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
`ifdef SEQDET_SCHED_STATS_EN
        ,
        .total_cnt (total_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_word(input vec_t v, input string tag);
        logic [W-1:0] word;
        logic [W-1:0] zcap;
        bit seen;
        word  = v.gnt[1] ? v.d1 : v.d0;
        data0 = v.d0;
        data1 = v.d1;
        req   = v.req;
        seen  = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clock);
            if (gnt != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_gnt"}, 32'(gnt), 32'(v.gnt));
        req = 2'b00;
        if (seen) begin
            zcap = '0;
            for (int i = 1; i <= W; i++) begin
                @(negedge Clock);
                chk({tag, "_det_w"}, 32'(det_w), 32'(word[W-i]));
                chk({tag, "_busy_shift"}, 32'(busy), 32'd1);
                chk({tag, "_done_early"}, 32'(done), 32'd0);
                zcap[W-i] = det_z;
            end
            @(negedge Clock);
            chk({tag, "_done"}, 32'(done), 32'd1);
            chk({tag, "_busy_report"}, 32'(busy), 32'd1);
            chk({tag, "_match_cnt"}, 32'(match_cnt), 32'(v.cnt));
            chk({tag, "_done_id"}, 32'(done_id), 32'(v.id));
            chk({tag, "_zmask"}, 32'(zcap), 32'(v.zmask));
            exp_total = exp_total + 16'(v.cnt);
            @(negedge Clock);
            chk({tag, "_done_after"}, 32'(done), 32'd0);
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
`ifdef SEQDET_SCHED_STATS_EN
            chk({tag, "_total"}, 32'(total_cnt), 32'(exp_total));
`endif
        end
    endtask

    initial begin
        int ng, nd, nbad;
        int gcyc[4];
        logic [1:0] gval[4];
        logic did[4];
        logic [CW-1:0] dcnt[4];

        tbl[0] = '{2'b01, 8'b1111_0000, 8'h00, 2'b01, 1'b0, 4'd2, 8'b0011_0000};
        tbl[1] = '{2'b01, 8'b1111_1111, 8'h00, 2'b01, 1'b0, 4'd6, 8'b0011_1111};
        tbl[2] = '{2'b01, 8'b1000_0000, 8'h00, 2'b01, 1'b0, 4'd0, 8'b0000_0000};
        tbl[3] = '{2'b01, 8'b0000_0111, 8'h00, 2'b01, 1'b0, 4'd1, 8'b0000_0001};
        tbl[4] = '{2'b01, 8'b1000_0000, 8'h00, 2'b01, 1'b0, 4'd0, 8'b0000_0000};
        tbl[5] = '{2'b10, 8'h00, 8'b1001_1001, 2'b10, 1'b1, 4'd2, 8'b0001_0001};

        // Reset state
        repeat (3) @(negedge Clock);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_det_w", 32'(det_w), 32'd0);
        chk("rst_det_z", 32'(det_z), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_match_cnt", 32'(match_cnt), 32'd0);
`ifdef SEQDET_SCHED_STATS_EN
        chk("rst_total", 32'(total_cnt), 32'd0);
`endif
        Resetn = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_word(tbl[k], $sformatf("vec%0d", k));
        end

        // Reset during the 4th bit abandons the word
        data0 = 8'hFF;
        req   = 2'b01;
        ng    = 0;
        for (int n = 0; n < 20 && ng == 0; n++) begin
            @(negedge Clock);
            if (gnt != 2'b00) ng = 1;
        end
        chk("abort_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        repeat (4) @(negedge Clock);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_det_w", 32'(det_w), 32'd0);
        chk("abort_match_cnt", 32'(match_cnt), 32'd0);
        exp_total = '0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        nbad = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge Clock);
            if (done || (gnt != 2'b00)) nbad++;
        end
        chk("abort_no_done", 32'(nbad), 32'd0);
        run_word('{2'b10, 8'h00, 8'b1001_1001, 2'b10, 1'b1, 4'd2, 8'b0001_0001}, "post_rst");

        // Both requesting for four words: alternate grants every W+2 cycles
        for (int k = 0; k < 4; k++) begin
            gcyc[k] = 0;
            gval[k] = 2'b00;
            did[k]  = 1'b0;
            dcnt[k] = '0;
        end
        data0 = 8'b1111_0000;
        data1 = 8'b1001_1001;
        req   = 2'b11;
        ng    = 0;
        nd    = 0;
        for (int c = 0; c < 80 && nd < 4; c++) begin
            @(negedge Clock);
            if (gnt != 2'b00 && ng < 4) begin
                gcyc[ng] = c;
                gval[ng] = gnt;
                ng++;
            end
            if (done) begin
                did[nd]  = done_id;
                dcnt[nd] = match_cnt;
                nd++;
                if (nd == 4) req = 2'b00;
            end
        end
        chk("rr_grants", 32'(ng), 32'd4);
        chk("rr_dones", 32'(nd), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_gnt%0d", k), 32'(gval[k]), (k % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("rr_id%0d", k), 32'(did[k]), 32'(k % 2));
            chk($sformatf("rr_cnt%0d", k), 32'(dcnt[k]), 32'd2);
            if (k > 0) begin
                chk($sformatf("rr_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'(W + 2));
            end
        end
        exp_total = exp_total + 16'd8;
        @(negedge Clock);
        chk("rr_idle_gnt", 32'(gnt), 32'd0);
`ifdef SEQDET_SCHED_STATS_EN
        chk("rr_total", 32'(total_cnt), 32'(exp_total));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
